gate_counter: RTL and testbench

- Parameterised synchronous up/down binary counter with parallel load and terminal-count output.
- Built from the primitive gate layer: the 2-input gate cells plus one flip-flop sub-module.
- First sequential stage above the combinational gate library. Feeds dividers, timers and address generators.
- Cascadable through en/tc for widths beyond WIDTH.

---
 rtl/gate_counter_pkg.sv | 6 +
 rtl/gate_cells.sv | 31 +++
 rtl/gate_dff.sv | 11 +
 rtl/gate_counter.sv | 38 +++
 tb/tb_gate_counter.sv | 109 ++++++++++
 5 files changed

// File: rtl/gate_counter_pkg.sv
// gate_counter_pkg: shared width default and direction encodings for gate_counter
package gate_counter_pkg;
    localparam int DEFAULT_WIDTH = 4;
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DOWN = 1'b0;
endpackage

// File: rtl/gate_cells.sv
// gate_cells: primitive 2-input gate cells and inverter
module gate_and (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a & b;
endmodule

module gate_or (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a | b;
endmodule

module gate_xor (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a ^ b;
endmodule

module gate_not (
    input  logic a,
    output logic y
);
    assign y = ~a;
endmodule

// File: rtl/gate_dff.sv
// gate_dff: one-bit D flip-flop with asynchronous active-low clear
module gate_dff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= 1'b0;
        else q <= d;
endmodule

// File: rtl/gate_counter.sv
// gate_counter: gate-level up/down counter with parallel load and cascadable terminal count
module gate_counter
    import gate_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc
);
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] diff, eq, cnt, sel_d, sel_c, nxt;
    logic             nload;

    // carry[i] high means every lower bit equals up and en is set, so bit i toggles
    assign carry[0] = en;
    gate_not u_nload (.a(load), .y(nload));
    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            gate_xor u_diff  (.a(q[i]), .b(up), .y(diff[i]));
            gate_not u_eq    (.a(diff[i]), .y(eq[i]));
            gate_and u_carry (.a(carry[i]), .b(eq[i]), .y(carry[i+1]));
            gate_xor u_cnt   (.a(q[i]), .b(carry[i]), .y(cnt[i]));
            gate_and u_sel_d (.a(load), .b(d[i]), .y(sel_d[i]));
            gate_and u_sel_c (.a(nload), .b(cnt[i]), .y(sel_c[i]));
            gate_or  u_nxt   (.a(sel_d[i]), .b(sel_c[i]), .y(nxt[i]));
            gate_dff u_ff    (.clk(clk), .rst_n(rst_n), .d(nxt[i]), .q(q[i]));
        end
    endgenerate
    // load suppresses tc so a loading stage never emits a cascade carry
    gate_and u_tc (.a(carry[WIDTH]), .b(nload), .y(tc));
endmodule

// File: tb/tb_gate_counter.sv
// tb_gate_counter: directed checks of gate_counter including a two-stage cascade
module tb_gate_counter;
    import gate_counter_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n, en, up, load;
    logic [3:0] d, q;
    logic       tc;
    logic       c_rst_n, c_en, c_load;
    logic [7:0] c_d;
    logic [3:0] cq_lo, cq_hi;
    logic       ctc_lo, ctc_hi;
    int         n_chk = 0;
    int         n_pass = 0;

    always #5 clk = ~clk;

    gate_counter #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .d(d), .q(q), .tc(tc)
    );
    gate_counter #(.WIDTH(4)) u_lo (
        .clk(clk), .rst_n(c_rst_n), .en(c_en), .up(DIR_UP), .load(c_load),
        .d(c_d[3:0]), .q(cq_lo), .tc(ctc_lo)
    );
    gate_counter #(.WIDTH(4)) u_hi (
        .clk(clk), .rst_n(c_rst_n), .en(ctc_lo), .up(DIR_UP), .load(c_load),
        .d(c_d[7:4]), .q(cq_hi), .tc(ctc_hi)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; up = DIR_UP; load = 1'b0; d = 4'h0;
        c_rst_n = 1'b0; c_en = 1'b0; c_load = 1'b0; c_d = 8'h00;
        #3;
        check("reset_q", q, 4'h0);
        check("reset_tc", tc, 1'b0);
        #9 rst_n = 1'b1;
        // async reset mid-count
        load = 1'b1; d = 4'h9; step();
        check("load9", q, 4'h9);
        load = 1'b0; en = 1'b1; up = DIR_UP;
        #1 rst_n = 1'b0;
        #1 check("async_rst", q, 4'h0);
        #2 rst_n = 1'b1;
        step(); check("post_rst1", q, 4'h1);
        step(); check("post_rst2", q, 4'h2);
        step(); check("post_rst3", q, 4'h3);
        // up wrap
        en = 1'b0; load = 1'b1; d = 4'hE; step();
        check("upw_E", q, 4'hE);
        load = 1'b0; en = 1'b1; up = DIR_UP; #1;
        check("upw_tcE", tc, 1'b0);
        step(); check("upw_F", q, 4'hF); check("upw_tcF", tc, 1'b1);
        step(); check("upw_0", q, 4'h0); check("upw_tc0", tc, 1'b0);
        // down wrap
        en = 1'b0; load = 1'b1; d = 4'h1; step();
        check("dnw_1", q, 4'h1);
        load = 1'b0; en = 1'b1; up = DIR_DOWN; #1;
        check("dnw_tc1", tc, 1'b0);
        step(); check("dnw_0", q, 4'h0); check("dnw_tc0", tc, 1'b1);
        step(); check("dnw_F", q, 4'hF); check("dnw_tcF", tc, 1'b0);
        // load priority and tc suppression
        en = 1'b0; load = 1'b1; d = 4'h5; step();
        check("lp_5", q, 4'h5);
        d = 4'h0; step();
        load = 1'b0; en = 1'b1; up = DIR_DOWN; #1;
        check("lp_tc_noload", tc, 1'b1);
        load = 1'b1; d = 4'hA; #1;
        check("lp_tc_load", tc, 1'b0);
        step(); check("lp_A", q, 4'hA);
        // hold
        load = 1'b0; en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(); check("hold", q, 4'hA);
        end
        // direction flip every cycle
        load = 1'b1; d = 4'h7; step();
        load = 1'b0; en = 1'b1;
        up = DIR_UP;   step(); check("dir_8a", q, 4'h8);
        up = DIR_DOWN; step(); check("dir_7a", q, 4'h7);
        up = DIR_UP;   step(); check("dir_8b", q, 4'h8);
        up = DIR_DOWN; step(); check("dir_7b", q, 4'h7);
        en = 1'b0;
        // cascade
        c_rst_n = 1'b1;
        c_load = 1'b1; c_d = 8'h0E; step();
        check("cas_0E", {cq_hi, cq_lo}, 8'h0E);
        c_load = 1'b0; c_en = 1'b1; #1;
        check("cas_tcE", ctc_lo, 1'b0);
        step(); check("cas_0F", {cq_hi, cq_lo}, 8'h0F); check("cas_tcF", ctc_lo, 1'b1);
        step(); check("cas_10", {cq_hi, cq_lo}, 8'h10);
        step(); check("cas_11", {cq_hi, cq_lo}, 8'h11);
        #1 c_rst_n = 1'b0;
        #1 check("cas_rst", {cq_hi, cq_lo}, 8'h00);
        check("cas_tchi", ctc_hi, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
